// File: rtl/rv32i_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : rv32i_pkg                                                        |
// | Purpose  : Shared RV32I load/store definitions: LSU state encoding, the     |
// |            load/store funct3 codes and funct3 legality helpers.            |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package rv32i_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    function automatic logic load_f3_ok(input logic [2:0] f3);
        return f3 inside {LB, LH, LW, LBU, LHU};
    endfunction

    function automatic logic store_f3_ok(input logic [2:0] f3);
        return f3 inside {SB, SH, SW};
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lsu_align                                                        |
// | Purpose  : Combinational lane steering. Stores: byte strobes and data      |
// |            replicated across lanes. Loads: lane pick plus sign/zero ext.   |
// | Ports    : funct3     in  3   width/sign code                              |
// |            offset     in  2   addr[1:0]                                    |
// |            store_data in  32  rs2 value                                    |
// |            rdata      in  32  memory read word                             |
// |            wstrb      out 4   byte strobes                                 |
// |            wdata      out 32  replicated store data                        |
// |            load_data  out 32  extended load result                         |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module lsu_align
    import rv32i_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        wstrb     = 4'b0000;
        wdata     = 32'h0;
        load_data = 32'h0;

        // Halfword selection uses offset[1] only and words ignore the offset,
        // so misaligned low bits behave as zero when not trapped upstream.
        lane_b = rdata[{offset, 3'b000} +: 8];
        lane_h = offset[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            LB:      load_data = {{24{lane_b[7]}}, lane_b};
            LBU:     load_data = {24'h0, lane_b};
            LH:      load_data = {{16{lane_h[15]}}, lane_h};
            LHU:     load_data = {16'h0, lane_h};
            LW:      load_data = rdata;
            default: load_data = 32'h0;
        endcase

        case (funct3)
            SB: begin
                wstrb = 4'b0001 << offset;
                wdata = {4{store_data[7:0]}};
            end
            SH: begin
                wstrb = offset[1] ? 4'b1100 : 4'b0011;
                wdata = {2{store_data[15:0]}};
            end
            SW: begin
                wstrb = 4'b1111;
                wdata = store_data;
            end
            default: begin
                wstrb = 4'b0000;
                wdata = 32'h0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lsu                                                              |
// | Purpose  : RV32I load/store unit. Accepts one op in IDLE, issues a single  |
// |            request, waits for grant (and read data for loads) and emits a  |
// |            one-cycle writeback pulse. Malformed ops and timeouts complete  |
// |            with err=1 and never write the register file.                   |
// | Ports    : clk, rst_n (async, active low)                                  |
// |            req_valid/req_ready, is_load, is_store, funct3, addr,           |
// |            store_data, rd_addr                     - execute side          |
// |            mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, mem_gnt,       |
// |            mem_rvalid, mem_rdata                   - memory side           |
// |            wb_valid, wb_we, wb_rd_addr, wb_data, err - writeback side      |
// | Macro    : LSU_MISALIGN_TRAP_EN - misaligned LH/LHU/LW/SH/SW complete with  |
// |            err=1 instead of accessing memory.                              |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module lsu
    import rv32i_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_addr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd_addr,
    output logic [31:0] wb_data,
    output logic        err
);

    localparam int              CW       = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(MEM_TIMEOUT - 1);

    lsu_state_t  state, state_nxt;
    logic        op_load;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] sdata_q;
    logic [4:0]  rd_q;
    logic        err_q;
    logic [31:0] ldata_q;
    logic [CW-1:0] cnt;

    logic        op_bad;
    logic        timeout;
    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata;
    logic [31:0] al_load;

    lsu_align u_align (
        .funct3     (f3_q),
        .offset     (addr_q[1:0]),
        .store_data (sdata_q),
        .rdata      (mem_rdata),
        .wstrb      (al_wstrb),
        .wdata      (al_wdata),
        .load_data  (al_load)
    );

    // Validity of the op presented this cycle, evaluated at acceptance.
`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign;
    always_comb begin
        misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                   ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    end
`endif

    always_comb begin
        op_bad = (is_load == is_store) ||
                 (is_load  && !load_f3_ok(funct3)) ||
                 (is_store && !store_f3_ok(funct3));
`ifdef LSU_MISALIGN_TRAP_EN
        op_bad = op_bad || misalign;
`endif
    end

    // The counter is cleared on entry to REQ/WAIT, so it holds the number of
    // cycles already spent there; the last allowed cycle is MEM_TIMEOUT-1.
    assign timeout = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        mem_req   = 1'b0;
        wb_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = op_bad ? ST_RESP : ST_REQ;
                end
            end
            ST_REQ: begin
                mem_req = 1'b1;
                if (mem_gnt) begin
                    state_nxt = op_load ? ST_WAIT : ST_RESP;
                end else if (timeout) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid || timeout) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                wb_valid  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_load <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= 32'h0;
            sdata_q <= 32'h0;
            rd_q    <= 5'd0;
            err_q   <= 1'b0;
            ldata_q <= 32'h0;
            cnt     <= '0;
        end else begin
            if ((state_nxt != state) || !((state == ST_REQ) || (state == ST_WAIT))) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if ((state == ST_IDLE) && req_valid) begin
                op_load <= is_load;
                f3_q    <= funct3;
                addr_q  <= addr;
                sdata_q <= store_data;
                rd_q    <= rd_addr;
                err_q   <= op_bad;
                ldata_q <= 32'h0;
            end

            if ((state == ST_REQ) && !mem_gnt && timeout) begin
                err_q <= 1'b1;
            end

            if (state == ST_WAIT) begin
                if (mem_rvalid) begin
                    ldata_q <= al_load;
                end else if (timeout) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign mem_we     = mem_req && !op_load;
    assign mem_addr   = {addr_q[31:2], 2'b00};
    assign mem_wstrb  = mem_we ? al_wstrb : 4'b0000;
    assign mem_wdata  = mem_we ? al_wdata : 32'h0;

    assign err        = wb_valid && err_q;
    assign wb_we      = wb_valid && op_load && !err_q && (rd_q != 5'd0);
    assign wb_rd_addr = rd_q;
    assign wb_data    = (wb_valid && op_load && !err_q) ? ldata_q : 32'h0;

endmodule
`default_nettype wire

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 The block SHALL have parameter MEM_TIMEOUT, default 255, meaning the maximum number of cycles to wait for mem_gnt or mem_rvalid before an error.
REQ-002 The block SHALL have these ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  execute stage presents a memory op.
- req_ready  out  1  LSU can accept; high only in IDLE.
- is_load / is_store  in  1 each  op kind; both high is illegal.
- funct3  in  3  RV32I width/sign code.
- addr  in  32  effective address (ALU rd_data).
- store_data  in  32  rs2 value.
- rd_addr  in  5  load destination.
- mem_req  out  1  memory request.
- mem_we  out  1  write enable.
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- mem_wstrb  out  4  byte strobes.
- mem_wdata  out  32  lane-steered store data.
- mem_gnt  in  1  request accepted.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read word.
- wb_valid  out  1  one-cycle completion pulse.
- wb_we  out  1  register write; load with rd_addr!=0.
- wb_rd_addr  out  5  destination.
- wb_data  out  32  extended load data; 0 for stores.
- err  out  1  qualifies wb_valid; op failed, no register write.

Function
REQ-003 The FSM SHALL have states IDLE, REQ, WAIT and RESP.
REQ-004 Acceptance SHALL occur on req_valid & req_ready (cycle 0): op, funct3, addr, store_data and rd_addr are registered; next state is REQ.
REQ-005 In REQ, mem_req SHALL stay high with stable outputs until mem_gnt; a granted store SHALL go to RESP, a granted load to WAIT.
REQ-006 In WAIT, the first mem_rvalid SHALL capture mem_rdata and go to RESP.
REQ-007 In RESP, wb_valid SHALL pulse for exactly one cycle, then return to IDLE.
REQ-008 Minimum latency SHALL be: store wb_valid at cycle 2, load wb_valid at cycle 3 (gnt in cycle 1, rvalid in cycle 2).
REQ-009 Loads SHALL decode as 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; the lane is selected by addr[1:0]; sign- or zero-extended to 32 bits.
REQ-010 Stores SHALL decode as 000 SB (strobe 1<<addr[1:0]), 001 SH (0011 or 1100 by addr[1]), 010 SW (1111); data SHALL be replicated across lanes.
REQ-011 An unsupported funct3 or is_load==is_store SHALL skip memory access and go to RESP with err=1.
REQ-012 A cycle counter SHALL count in REQ and WAIT and clear on every state change; reaching MEM_TIMEOUT SHALL go to RESP with err=1.
REQ-013 mem_rvalid outside WAIT SHALL be ignored.
REQ-014 mem_gnt outside REQ SHALL be ignored.
REQ-015 When err=1, wb_we SHALL be 0.

Reset
REQ-016 rst_n low SHALL force IDLE immediately, mid-operation included, abandoning any outstanding access.
REQ-017 During reset, mem_req, wb_valid, wb_we and err SHALL be 0; data, address and strobe outputs SHALL be 0; the counter SHALL be 0.
REQ-018 req_ready SHALL be 1 in the first cycle after rst_n deasserts.

Configuration
REQ-019 With LSU_MISALIGN_TRAP_EN defined, a halfword with addr[0]=1 or a word with addr[1:0]!=0 SHALL skip memory and complete with err=1.
REQ-020 Without LSU_MISALIGN_TRAP_EN, the offending low address bits SHALL be treated as zero and the access SHALL proceed normally.

Structure
REQ-021 Shared package rv32i_pkg SHALL hold the lsu_state_t enum and the LB/LH/LW/LBU/LHU/SB/SH/SW funct3 localparams.
REQ-022 Lane steering and extension SHALL live in combinational sub-module lsu_align, instantiated once.

Verification
REQ-023 SW: addr 0x104, data 0xDEADBEEF, gnt in cycle 1 -> mem_addr 0x104, wstrb 1111, wdata 0xDEADBEEF; wb_valid at cycle 2 with wb_we=0.
REQ-024 LB / LBU: addr 0x203, rdata 0x80xxxxxx -> LB wb_data 0xFFFFFF80; LBU wb_data 0x00000080.
REQ-025 SH addr 0x12, data 0x0000ABCD -> wstrb 1100, wdata 0xABCDABCD; LH addr 0x12, rdata 0x7FFF0000 -> wb_data 0x00007FFF.
REQ-026 Load, gnt withheld for MEM_TIMEOUT cycles -> wb_valid with err=1, wb_we=0, then req_ready=1.
REQ-027 LW to addr 0x101 -> err=1 and no mem_req with the macro defined; without it, mem_addr 0x100 and normal completion.
REQ-028 rst_n low while in WAIT, then a stray rvalid after release -> state IDLE, no wb_valid.
